frame_checker: RTL and testbench

//  Receive-side counterpart of frame_generator: AXIS sink that consumes test frames returned by the DUT

---
 rtl/frame_checker.sv | 223 ++++++++++++++++++++++
 tb/tb_frame_checker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_checker.sv
// frame_checker -- receive-side AXIS sink for test traffic.
//
// Consumes frames returned by the router, keeps the frames whose stream ID
// matches cfg_id, and maintains frame/byte/error/sequence-gap statistics.
// Frames whose first beat arrives while RUN is active are counted. A frame that
// is in progress when stop arrives is finished in FLUSH and still counted.
//
// Optional feature macro: FRAME_CHECKER_LATENCY_EN
//   When defined, the TX timestamp (big-endian, bytes SEQ_OFFSET+4..+7 of the
//   first beat) is turned into a latency against the timestamp input. Latency
//   is accumulated into lat_sum and tracked as a maximum in lat_max.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   ready          1 in IDLE (a start is accepted)
//   start, stop    1-cycle control pulses from the traffic controller
//   cfg_id         stream ID to count
//   timestamp      free-running cycle counter shared with the generator
//   axis_s_*       AXIS sink (data/keep/last/user/id/valid in, ready out)
//   rx_frames      counted frames (good + bad)
//   rx_bytes       bytes of counted frames
//   err_frames     counted frames with a user error or an illegal length
//   seq_errors     good counted frames with an unexpected sequence number
//   other_frames   frames with a foreign stream ID seen in RUN/FLUSH
//   lat_sum/max    (FRAME_CHECKER_LATENCY_EN only) latency statistics
module frame_checker #(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 3,
  parameter int SEQ_OFFSET = 42,
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1514
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    ready,
  input  logic                    start,
  input  logic                    stop,
  input  logic [ID_WIDTH-1:0]     cfg_id,
  input  logic [31:0]             timestamp,
  input  logic [DATA_WIDTH-1:0]   axis_s_data,
  input  logic [DATA_WIDTH/8-1:0] axis_s_keep,
  input  logic                    axis_s_last,
  input  logic [DATA_WIDTH/8-1:0] axis_s_user,
  input  logic [ID_WIDTH-1:0]     axis_s_id,
  input  logic                    axis_s_valid,
  output logic                    axis_s_ready,
  output logic [63:0]             rx_frames,
  output logic [63:0]             rx_bytes,
  output logic [31:0]             err_frames,
  output logic [31:0]             seq_errors,
  output logic [31:0]             other_frames
`ifdef FRAME_CHECKER_LATENCY_EN
  ,
  output logic [63:0]             lat_sum,
  output logic [31:0]             lat_max
`endif
);

  localparam int KEEP_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  function automatic logic [15:0] popcount(input logic [KEEP_W-1:0] k);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      c = c + 16'(k[i]);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Big-endian 32-bit word: byte 'off' is the most significant byte.
  function automatic logic [31:0] be_word(input logic [DATA_WIDTH-1:0] d, input int off);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      w[31-8*b -: 8] = d[8*(off+b) +: 8];
    end
    return w;
  endfunction

  state_t        state_q, state_d;
  logic          ready_q;
  logic          in_frame_q, in_frame_d;
  logic          acc, first, last_acc, clr;

  logic [15:0]   len_p0;
  logic          err_p0;
  logic          cnt_p0;
  logic          match_p0;
  logic [31:0]   seq_p0;

  logic [15:0]   len_cur;
  logic          err_cur;
  logic          cnt_cur;
  logic          match_cur;
  logic [31:0]   seq_cur;
  logic          bad_cur;

  logic          seq_valid_q;
  logic [31:0]   seq_exp_q;

  assign axis_s_ready = ready_q;
  assign ready        = (state_q == S_IDLE);

  assign acc      = axis_s_valid & ready_q;
  assign first    = acc & ~in_frame_q;
  assign last_acc = acc & axis_s_last;
  assign clr      = start & (state_q == S_IDLE);

  assign in_frame_d = acc ? ~axis_s_last : in_frame_q;

  // Current-beat view of the frame; a first beat restarts every accumulator so
  // single-beat frames are handled without an extra cycle.
  assign len_cur   = first ? popcount(axis_s_keep) : sat_add16(len_p0, popcount(axis_s_keep));
  assign err_cur   = (first ? 1'b0 : err_p0) | (|axis_s_user);
  assign cnt_cur   = first ? (state_q == S_RUN) : cnt_p0;
  assign match_cur = first ? (axis_s_id == cfg_id) : match_p0;
  assign seq_cur   = first ? be_word(axis_s_data, SEQ_OFFSET) : seq_p0;
  assign bad_cur   = err_cur | (len_cur < 16'(MIN_LEN)) | (len_cur > 16'(MAX_LEN));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      // in_frame_d covers a stop that lands on a frame's first or last beat.
      S_RUN:   if (stop) state_d = in_frame_d ? S_FLUSH : S_IDLE;
      S_FLUSH: if (last_acc) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      in_frame_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= 1'b1;
      in_frame_q <= in_frame_d;
    end
  end

  // ---- stage p0: per-frame accumulators, loaded on every accepted beat ----
  always_ff @(posedge clk) begin
    if (acc) begin
      len_p0   <= len_cur;
      err_p0   <= err_cur;
      cnt_p0   <= cnt_cur;
      match_p0 <= match_cur;
      seq_p0   <= seq_cur;
    end
  end

  // ---- statistics: registered update on the accepted last beat ----
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rx_frames    <= '0;
      rx_bytes     <= '0;
      err_frames   <= '0;
      seq_errors   <= '0;
      other_frames <= '0;
      seq_valid_q  <= 1'b0;
      seq_exp_q    <= '0;
    end else if (last_acc && cnt_cur) begin
      if (match_cur) begin
        rx_frames  <= rx_frames + 64'd1;
        rx_bytes   <= rx_bytes + 64'(len_cur);
        err_frames <= err_frames + 32'(bad_cur);
        if (!bad_cur) begin
          if (seq_valid_q && (seq_cur != seq_exp_q)) begin
            seq_errors <= seq_errors + 32'd1;
          end
          // Always resynchronise on the received value.
          seq_exp_q   <= seq_cur + 32'd1;
          seq_valid_q <= 1'b1;
        end
      end else begin
        other_frames <= other_frames + 32'd1;
      end
    end
  end

`ifdef FRAME_CHECKER_LATENCY_EN
  logic [31:0] lat_p0;
  logic [31:0] lat_cur;
  logic        unused_bits;

  assign unused_bits = ^axis_s_data;
  assign lat_cur = first ? (timestamp - be_word(axis_s_data, SEQ_OFFSET + 4)) : lat_p0;

  // ---- stage p0: latency sampled on the first beat ----
  always_ff @(posedge clk) begin
    if (acc) lat_p0 <= lat_cur;
  end

  // ---- latency statistics for good counted frames ----
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lat_sum <= '0;
      lat_max <= '0;
    end else if (last_acc && cnt_cur && match_cur && !bad_cur) begin
      lat_sum <= lat_sum + 64'(lat_cur);
      if (lat_cur > lat_max) lat_max <= lat_cur;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{axis_s_data, timestamp};
`endif

endmodule

// File: tb/tb_frame_checker.sv
module tb_frame_checker;

  logic         clk = 1'b0;
  logic         rst;
  logic         ready;
  logic         start, stop;
  logic [2:0]   cfg_id;
  logic [31:0]  timestamp;
  logic [511:0] axis_s_data;
  logic [63:0]  axis_s_keep;
  logic         axis_s_last;
  logic [63:0]  axis_s_user;
  logic [2:0]   axis_s_id;
  logic         axis_s_valid;
  logic         axis_s_ready;
  logic [63:0]  rx_frames, rx_bytes;
  logic [31:0]  err_frames, seq_errors, other_frames;
`ifdef FRAME_CHECKER_LATENCY_EN
  logic [63:0]  lat_sum;
  logic [31:0]  lat_max;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_checker dut (
    .clk(clk), .rst(rst), .ready(ready), .start(start), .stop(stop),
    .cfg_id(cfg_id), .timestamp(timestamp),
    .axis_s_data(axis_s_data), .axis_s_keep(axis_s_keep), .axis_s_last(axis_s_last),
    .axis_s_user(axis_s_user), .axis_s_id(axis_s_id), .axis_s_valid(axis_s_valid),
    .axis_s_ready(axis_s_ready),
    .rx_frames(rx_frames), .rx_bytes(rx_bytes), .err_frames(err_frames),
    .seq_errors(seq_errors), .other_frames(other_frames)
`ifdef FRAME_CHECKER_LATENCY_EN
    , .lat_sum(lat_sum), .lat_max(lat_max)
`endif
  );

  function automatic logic [511:0] mk_first(input logic [31:0] seq, input logic [31:0] ts);
    logic [511:0] d;
    d = '0;
    d[7:0] = 8'hA5;
    d[511:504] = 8'h5A;
    for (int b = 0; b < 4; b++) begin
      d[8*(42+b) +: 8] = seq[31-8*b -: 8];
      d[8*(46+b) +: 8] = ts[31-8*b -: 8];
    end
    return d;
  endfunction

  function automatic logic [63:0] keep_of(input int nb);
    logic [63:0] k;
    k = '0;
    for (int i = 0; i < nb; i++) k[i] = 1'b1;
    return k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic send_beat(input logic [511:0] d, input int nb, input logic lst,
                           input logic usr, input logic [2:0] id);
    axis_s_data  = d;
    axis_s_keep  = keep_of(nb);
    axis_s_user  = usr ? 64'h1 : 64'h0;
    axis_s_last  = lst;
    axis_s_id    = id;
    axis_s_valid = 1'b1;
    tick();
    axis_s_valid = 1'b0;
    axis_s_last  = 1'b0;
    axis_s_user  = '0;
  endtask

  task automatic send_frame(input logic [2:0] id, input int nbytes, input logic [31:0] seq,
                            input logic [31:0] ts, input int err_beat);
    int rem;
    int b;
    int nb;
    rem = nbytes;
    b = 0;
    while (rem > 0) begin
      nb = (rem > 64) ? 64 : rem;
      rem = rem - nb;
      send_beat((b == 0) ? mk_first(seq, ts) : 512'd0, nb, rem == 0, b == err_beat, id);
      b++;
    end
  endtask

  task automatic restart();
    stop = 1'b1;
    tick();
    start = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (axis_s_ready !== 1'b0) begin errors++; $display("FAIL rst_axis_ready got %b want 0", axis_s_ready); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", ready); end
    checks++; if (rx_frames !== 64'd0 || rx_bytes !== 64'd0) begin errors++; $display("FAIL rst_rx got %0d/%0d want 0/0", rx_frames, rx_bytes); end
    checks++; if (err_frames !== 32'd0 || seq_errors !== 32'd0 || other_frames !== 32'd0) begin errors++; $display("FAIL rst_err got %0d/%0d/%0d want 0/0/0", err_frames, seq_errors, other_frames); end
    rst = 1'b0;
    tick();
    checks++; if (axis_s_ready !== 1'b1) begin errors++; $display("FAIL post_rst_axis_ready got %b want 1", axis_s_ready); end
  endtask

  task automatic test_basic();
    start = 1'b1;
    tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL basic_ready_run got %b want 0", ready); end
    for (int i = 0; i < 10; i++) send_frame(3'd2, 64, i, 0, -1);
    checks++; if (rx_frames !== 64'd10) begin errors++; $display("FAIL basic_rx_frames got %0d want 10", rx_frames); end
    checks++; if (rx_bytes !== 64'd640) begin errors++; $display("FAIL basic_rx_bytes got %0d want 640", rx_bytes); end
    checks++; if (seq_errors !== 32'd0) begin errors++; $display("FAIL basic_seq_errors got %0d want 0", seq_errors); end
    checks++; if (err_frames !== 32'd0) begin errors++; $display("FAIL basic_err_frames got %0d want 0", err_frames); end
  endtask

  task automatic test_seq_gap();
    restart();
    checks++; if (rx_frames !== 64'd0) begin errors++; $display("FAIL seq_start_clear got %0d want 0", rx_frames); end
    send_frame(3'd2, 64, 5, 0, -1);
    send_frame(3'd2, 64, 6, 0, -1);
    send_frame(3'd2, 64, 8, 0, -1);
    send_frame(3'd2, 64, 9, 0, -1);
    checks++; if (seq_errors !== 32'd1) begin errors++; $display("FAIL seq_gap got %0d want 1", seq_errors); end
    send_frame(3'd2, 64, 3, 0, -1);
    checks++; if (seq_errors !== 32'd2) begin errors++; $display("FAIL seq_back got %0d want 2", seq_errors); end
    send_frame(3'd2, 64, 4, 0, -1);
    checks++; if (seq_errors !== 32'd2) begin errors++; $display("FAIL seq_resync got %0d want 2", seq_errors); end
    // Foreign ID: counted in other_frames only, does not touch sequence state.
    send_frame(3'd5, 128, 100, 0, -1);
    checks++; if (other_frames !== 32'd1) begin errors++; $display("FAIL other_frames got %0d want 1", other_frames); end
    send_frame(3'd2, 64, 5, 0, -1);
    checks++; if (seq_errors !== 32'd2 || rx_frames !== 64'd7) begin errors++; $display("FAIL other_no_effect got seq %0d rx %0d want 2 7", seq_errors, rx_frames); end
  endtask

  task automatic test_len_err();
    restart();
    send_frame(3'd2, 1514, 0, 0, 12);
    send_frame(3'd2, 40, 7, 0, -1);
    checks++; if (err_frames !== 32'd2) begin errors++; $display("FAIL len_err_frames got %0d want 2", err_frames); end
    checks++; if (rx_frames !== 64'd2) begin errors++; $display("FAIL len_rx_frames got %0d want 2", rx_frames); end
    checks++; if (seq_errors !== 32'd0) begin errors++; $display("FAIL len_seq got %0d want 0", seq_errors); end
    send_frame(3'd2, 60, 1, 0, -1);
    checks++; if (err_frames !== 32'd2) begin errors++; $display("FAIL len_min_ok got %0d want 2", err_frames); end
    send_frame(3'd2, 1515, 2, 0, -1);
    send_frame(3'd2, 59, 3, 0, -1);
    checks++; if (err_frames !== 32'd4) begin errors++; $display("FAIL len_bounds got %0d want 4", err_frames); end
    // 1025 full beats: length saturates at 65535.
    send_frame(3'd2, 65600, 4, 0, -1);
    checks++; if (rx_bytes !== 64'd68723) begin errors++; $display("FAIL len_sat_bytes got %0d want 68723", rx_bytes); end
    checks++; if (err_frames !== 32'd5 || rx_frames !== 64'd6) begin errors++; $display("FAIL len_sat_err got %0d/%0d want 5/6", err_frames, rx_frames); end
  endtask

  task automatic test_start_mid_frame();
    stop = 1'b1;
    tick();
    send_beat(mk_first(0, 0), 64, 1'b0, 1'b0, 3'd2);
    start = 1'b1;
    send_beat(512'd0, 64, 1'b0, 1'b0, 3'd2);
    checks++; if (err_frames !== 32'd0) begin errors++; $display("FAIL mid_clear got %0d want 0", err_frames); end
    send_beat(512'd0, 64, 1'b1, 1'b0, 3'd2);
    checks++; if (rx_frames !== 64'd0) begin errors++; $display("FAIL mid_dropped got %0d want 0", rx_frames); end
    send_frame(3'd2, 64, 0, 0, -1);
    checks++; if (rx_frames !== 64'd1 || rx_bytes !== 64'd64) begin errors++; $display("FAIL mid_next got %0d/%0d want 1/64", rx_frames, rx_bytes); end
  endtask

  task automatic test_stop_flush();
    send_beat(mk_first(1, 0), 64, 1'b0, 1'b0, 3'd2);
    stop = 1'b1;
    send_beat(512'd0, 64, 1'b0, 1'b0, 3'd2);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", ready); end
    for (int b = 2; b < 23; b++) begin
      if (b == 5) start = 1'b1;
      send_beat(512'd0, 64, 1'b0, 1'b0, 3'd2);
    end
    checks++; if (ready !== 1'b0 || rx_frames !== 64'd1) begin errors++; $display("FAIL flush_hold got ready %b rx %0d want 0 1", ready, rx_frames); end
    send_beat(512'd0, 42, 1'b1, 1'b0, 3'd2);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flush_done_ready got %b want 1", ready); end
    checks++; if (rx_frames !== 64'd2 || rx_bytes !== 64'd1578) begin errors++; $display("FAIL flush_count got %0d/%0d want 2/1578", rx_frames, rx_bytes); end
    checks++; if (seq_errors !== 32'd0) begin errors++; $display("FAIL flush_seq got %0d want 0", seq_errors); end
    send_frame(3'd2, 64, 9, 0, -1);
    checks++; if (rx_frames !== 64'd2) begin errors++; $display("FAIL idle_not_counted got %0d want 2", rx_frames); end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    checks++; if (ready !== 1'b0 || rx_frames !== 64'd0) begin errors++; $display("FAIL start_wins got ready %b rx %0d want 0 0", ready, rx_frames); end
  endtask

`ifdef FRAME_CHECKER_LATENCY_EN
  task automatic test_latency();
    restart();
    timestamp = 32'd150;
    send_frame(3'd2, 64, 0, 32'd100, -1);
    timestamp = 32'd260;
    send_frame(3'd2, 64, 1, 32'd200, -1);
    checks++; if (lat_sum !== 64'd110 || lat_max !== 32'd60) begin errors++; $display("FAIL lat_basic got %0d/%0d want 110/60", lat_sum, lat_max); end
    timestamp = 32'd16;
    send_frame(3'd2, 64, 2, 32'hFFFF_FFF0, -1);
    checks++; if (lat_sum !== 64'd142 || lat_max !== 32'd60) begin errors++; $display("FAIL lat_wrap got %0d/%0d want 142/60", lat_sum, lat_max); end
    restart();
    send_frame(3'd2, 64, 3, 32'hFFFF_FFF0, -1);
    checks++; if (lat_sum !== 64'd32 || lat_max !== 32'd32) begin errors++; $display("FAIL lat_restart got %0d/%0d want 32/32", lat_sum, lat_max); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    cfg_id = 3'd2;
    timestamp = '0;
    axis_s_data = '0;
    axis_s_keep = '0;
    axis_s_last = 1'b0;
    axis_s_user = '0;
    axis_s_id = '0;
    axis_s_valid = 1'b0;
    test_reset();
    test_basic();
    test_seq_gap();
    test_len_err();
    test_start_mid_frame();
    test_stop_flush();
`ifdef FRAME_CHECKER_LATENCY_EN
    test_latency();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
